// File: rtl/hazard_pkg.sv
// Shared opcode constants, hazard FSM state type and source-register usage decode
// for the hazard control unit.
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_JAL    = 7'd111;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MEM_WAIT   = 2'd2
  } hz_state_e;

  // Returns {uses_rs2, uses_rs1} for the given opcode.
  function automatic logic [1:0] src_use(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: src_use = 2'b11;
      OP_IMM, OP_LOAD, OP_JALR:  src_use = 2'b01;
      default:                   src_use = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Combinational source-register extraction for the instruction in ID.
module hazard_src_decode
  import hazard_pkg::*;
(
  input  logic [31:0] id_instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [1:0] w_use;
  logic       w_unused_bits;

  assign w_use         = src_use(id_instr[6:0]);
  assign rs1           = id_instr[19:15];
  assign rs2           = id_instr[24:20];
  assign uses_rs1      = w_use[0];
  assign uses_rs2      = w_use[1];
  assign w_unused_bits = ^{id_instr[31:25], id_instr[14:7]};

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / memory-wait / branch-flush hazard control for the 5-stage core.
// Optional performance counters enabled with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mem_is_load,
  input  logic        dmem_ready,
  input  logic        branch_taken_ex,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pipe_freeze,
  output logic [1:0]  hz_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned PEND_N = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  logic [4:0] w_rs1, w_rs2;
  logic       w_use1, w_use2;
  logic       w_ex_load, w_ex_hit, w_pend_hit;
  logic       w_mem_wait, w_load_hazard;
  hz_state_e  w_next, r_state;

  hazard_src_decode u_src_decode (
    .id_instr (id_instr),
    .rs1      (w_rs1),
    .rs2      (w_rs2),
    .uses_rs1 (w_use1),
    .uses_rs2 (w_use2)
  );

  assign w_ex_load  = ex_valid & ex_mem_read & (ex_rd != '0);
  assign w_ex_hit   = w_ex_load & ((w_use1 & (w_rs1 == ex_rd)) | (w_use2 & (w_rs2 == ex_rd)));
  assign w_mem_wait = mem_is_load & ~dmem_ready;
  assign w_load_hazard = id_valid & (w_ex_hit | w_pend_hit);

  // Loads that have left EX but whose data is not yet forwardable; valid entries never hold x0.
  if (LOAD_LAT > 1) begin : g_pend
    logic [PEND_N-1:0] r_pend_v;
    logic [4:0]        r_pend_rd [PEND_N];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pend_v <= '0;
        for (int unsigned i = 0; i < PEND_N; i++) r_pend_rd[i] <= '0;
      end else if (!w_mem_wait) begin
        r_pend_v[0]  <= w_ex_load;
        r_pend_rd[0] <= ex_rd;
        for (int unsigned i = 1; i < PEND_N; i++) begin
          r_pend_v[i]  <= r_pend_v[i-1];
          r_pend_rd[i] <= r_pend_rd[i-1];
        end
      end
    end

    always_comb begin
      w_pend_hit = 1'b0;
      for (int unsigned i = 0; i < PEND_N; i++) begin
        if (r_pend_v[i] && ((w_use1 && (w_rs1 == r_pend_rd[i])) ||
                            (w_use2 && (w_rs2 == r_pend_rd[i]))))
          w_pend_hit = 1'b1;
      end
    end
  end else begin : g_no_pend
    assign w_pend_hit = 1'b0;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_freeze  = 1'b0;
    w_next       = HZ_RUN;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (w_mem_wait) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      w_next      = HZ_MEM_WAIT;
    end else if (branch_taken_ex) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      w_next       = HZ_LOAD_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HZ_RUN;
    else        r_state <= w_next;
  end

  assign hz_state = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_ls_cnt, r_mw_cnt, r_fl_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ls_cnt <= '0;
      r_mw_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      if (r_state == HZ_LOAD_STALL && r_ls_cnt != '1) r_ls_cnt <= r_ls_cnt + CNT_W'(1);
      if (r_state == HZ_MEM_WAIT && r_mw_cnt != '1)   r_mw_cnt <= r_mw_cnt + CNT_W'(1);
      if (if_id_flush && r_fl_cnt != '1)              r_fl_cnt <= r_fl_cnt + CNT_W'(1);
    end
  end

  assign load_stall_cnt = r_ls_cnt;
  assign mem_wait_cnt   = r_mw_cnt;
  assign flush_cnt      = r_fl_cnt;
`endif

endmodule
